ddr2_v11_0_if_csr_m0_chan_arbiter: RTL and testbench
====================================================

DDR2_V11_0_IF_CSR_M0_CHAN_ARBITER -- requirements
Module: ddr2_v11_0_if_csr_m0_chan_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, setting the payload width of all data ports.
REQ-002 The block SHALL have parameter CH0_ID, default 8'd0, the channel number stamped on packets from input 0.
REQ-003 The block SHALL have parameter CH1_ID, default 8'd1, the channel number stamped on packets from input 1.
REQ-004 Ports, in this order:
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  in0_valid / in1_valid  in  1  source beat valid
  in0_ready / in1_ready  out  1  beat accepted when ready&valid
  in0_data / in1_data  in  DATA_W  payload
  in0_startofpacket / in1_startofpacket  in  1  first beat of packet
  in0_endofpacket / in1_endofpacket  in  1  last beat of packet
  out_valid  out  1  output beat valid
  out_ready  in  1  sink backpressure
  out_data  out  DATA_W  payload of granted input
  out_channel  out  8  CHn_ID of granted input
  out_startofpacket / out_endofpacket  out  1  framing of granted input
  grant  out  2  one-hot current grant, 2'b00 when idle
  sop_err  out  1  one-cycle pulse on protocol error (REQ-014)

Function
REQ-005 FSM states SHALL be IDLE, BUSY0, BUSY1.
REQ-006 IDLE: in0_ready=in1_ready=0; grant=00; no beat passes.
REQ-007 IDLE -> BUSYn next cycle when only inN_valid=1; when both valid, SHALL go to the input not served last (last_grant pointer, reset value selects input 0 first).
REQ-008 BUSYn: inN_ready SHALL equal the downstream-ready term (REQ-016); the other input's ready SHALL be 0; grant=one-hot n.
REQ-009 BUSYn: a beat SHALL transfer on inN_valid&inN_ready, carrying data/sop/eop unchanged and out_channel=CHn_ID.
REQ-010 BUSYn SHALL be held for the whole packet; exit to IDLE SHALL occur only on the cycle after a transferred beat with inN_endofpacket=1; last_grant SHALL update to n on that transfer.
REQ-011 A single-beat packet (sop=eop=1) SHALL occupy exactly one BUSY transfer cycle.
REQ-012 Arbitration bubble: exactly one IDLE cycle SHALL separate consecutive packets; minimum packet-to-packet spacing is 2 cycles.
REQ-013 A valid drop of the granted input mid-packet SHALL stall the grant (no switch, no timeout).
REQ-014 In BUSYn, a transferred beat with sop=1 other than the packet's first beat SHALL pulse sop_err for one cycle; the beat SHALL still pass unchanged.
REQ-015 The non-granted input SHALL never be dropped or reordered; its beats wait with ready=0.

Reset
REQ-017 While reset=1 at a clock edge: state=IDLE, last_grant=input 1 (so input 0 wins first tie), sop_err=0, output register (if present) emptied.
REQ-018 Outputs during/after reset: out_valid=0, in0_ready=in1_ready=0, grant=00, out_channel=0, out_data=0, sop/eop=0.
REQ-019 Reset asserted mid-packet SHALL abandon the packet; no further beats of it are forwarded until a new grant.

Configuration
REQ-016 Macro DDR2_V11_0_IF_CSR_M0_CHAN_ARBITER_OUT_REG_EN:
  defined: output side SHALL be a 2-entry skid register; all out_* registered; latency 1 cycle; downstream-ready term = skid not full; full throughput under continuous out_ready=1; EOP exit of REQ-010 counted at input acceptance.
  undefined: out_* SHALL be combinational from the granted input; latency 0; downstream-ready term = out_ready; out_valid=0 when IDLE.

Verification
REQ-020 Single source: in0 sends 3-beat packet 0xA1,0xA2,0xA3, out_ready=1 -> out carries 0xA1(sop),0xA2,0xA3(eop), out_channel=0, grant=01, in1_ready=0 throughout.
REQ-021 Tie: both valid from reset, 2-beat packets -> in0 packet first, one IDLE cycle, then in1 packet with out_channel=1; repeat -> order alternates 0,1,0,1.
REQ-022 Backpressure: out_ready toggles 1,0,1,0 during in1 4-beat packet 0x10..0x13 -> all four bytes delivered once, in order, no switch to in0 though in0_valid=1.
REQ-023 Mid-packet reset: assert reset after beat 2 of 4 from in0 -> next cycle out_valid=0, grant=00; after release with both valid, in0 granted first.
REQ-024 Protocol error: in0 sends sop on beats 1 and 3 of a 4-beat packet -> sop_err pulses exactly once, at beat 3 transfer; all 4 beats forwarded.
REQ-025 Build both with and without OUT_REG_EN: same byte streams as REQ-020/021; latency 1 vs 0 cycles from input acceptance to out_valid.

Source files
------------

// File: rtl/ddr2_v11_0_if_csr_m0_chan_arbiter.sv
// Two-input packet arbiter: round-robin grant held for a whole packet.
// Option: DDR2_V11_0_IF_CSR_M0_CHAN_ARBITER_OUT_REG_EN adds a 2-entry output skid.
`timescale 1ns/1ps
module ddr2_v11_0_if_csr_m0_chan_arbiter #(
  parameter int         DATA_W = 8,
  parameter logic [7:0] CH0_ID = 8'd0,
  parameter logic [7:0] CH1_ID = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic              in1_valid,
  output logic              in0_ready,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in0_startofpacket,
  input  logic              in1_startofpacket,
  input  logic              in0_endofpacket,
  input  logic              in1_endofpacket,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_channel,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic [1:0]        grant,
  output logic              sop_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY0 = 2'd1,
    S_BUSY1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_first;
  logic                r_sop_err;
  logic                w_busy0;
  logic                w_busy1;
  logic                w_dn_rdy;
  logic                w_xfer0;
  logic                w_xfer1;
  logic                w_xfer;
  logic                w_sel_valid;
  logic [DATA_W-1:0]   w_sel_data;
  logic [7:0]          w_sel_ch;
  logic                w_sel_sop;
  logic                w_sel_eop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: round-robin on ties, hold grant until the EOP beat moves
  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (in0_valid && in1_valid)
          w_next = r_last ? S_BUSY0 : S_BUSY1;
        else if (in0_valid)
          w_next = S_BUSY0;
        else if (in1_valid)
          w_next = S_BUSY1;
      end
      (r_state == S_BUSY0): begin
        if (w_xfer0 && in0_endofpacket) w_next = S_IDLE;
      end
      (r_state == S_BUSY1): begin
        if (w_xfer1 && in1_endofpacket) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: grant, input readies and the granted-input mux
  always_comb begin
    w_busy0     = (r_state == S_BUSY0) && !reset;
    w_busy1     = (r_state == S_BUSY1) && !reset;
    grant       = {w_busy1, w_busy0};
    in0_ready   = w_busy0 && w_dn_rdy;
    in1_ready   = w_busy1 && w_dn_rdy;
    w_xfer0     = in0_valid && in0_ready;
    w_xfer1     = in1_valid && in1_ready;
    w_xfer      = w_xfer0 || w_xfer1;
    w_sel_valid = (w_busy0 && in0_valid) || (w_busy1 && in1_valid);
    w_sel_data  = w_busy1 ? in1_data : in0_data;
    w_sel_ch    = w_busy1 ? CH1_ID : CH0_ID;
    w_sel_sop   = w_busy1 ? in1_startofpacket : in0_startofpacket;
    w_sel_eop   = w_busy1 ? in1_endofpacket : in0_endofpacket;
  end

  // Last-served pointer; reset value lets input 0 win the first tie
  always_ff @(posedge clk) begin
    if (reset)
      r_last <= 1'b1;
    else if (w_xfer0 && in0_endofpacket)
      r_last <= 1'b0;
    else if (w_xfer1 && in1_endofpacket)
      r_last <= 1'b1;
  end

  // Track first beat of a packet and flag a repeated SOP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first   <= 1'b1;
      r_sop_err <= 1'b0;
    end else begin
      r_sop_err <= w_xfer && w_sel_sop && !r_first;
      if (r_state == S_IDLE) r_first <= 1'b1;
      else if (w_xfer)       r_first <= 1'b0;
    end
  end

  assign sop_err = r_sop_err;

`ifdef DDR2_V11_0_IF_CSR_M0_CHAN_ARBITER_OUT_REG_EN
  logic [DATA_W-1:0] r_mem_d   [2];
  logic [7:0]        r_mem_ch  [2];
  logic [1:0]        r_mem_sop;
  logic [1:0]        r_mem_eop;
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_cnt;
  logic              w_pop;

  // Skid occupancy gates acceptance and drives the registered outputs
  always_comb begin
    w_dn_rdy          = (r_cnt != 2'd2);
    out_valid         = (r_cnt != 2'd0) && !reset;
    w_pop             = out_valid && out_ready;
    out_data          = out_valid ? r_mem_d[r_rd]  : '0;
    out_channel       = out_valid ? r_mem_ch[r_rd] : '0;
    out_startofpacket = out_valid && r_mem_sop[r_rd];
    out_endofpacket   = out_valid && r_mem_eop[r_rd];
  end

  // Two-entry skid FIFO between arbiter and sink
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_d   <= '{default: '0};
      r_mem_ch  <= '{default: '0};
      r_mem_sop <= '0;
      r_mem_eop <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_mem_d[r_wr]   <= w_sel_data;
        r_mem_ch[r_wr]  <= w_sel_ch;
        r_mem_sop[r_wr] <= w_sel_sop;
        r_mem_eop[r_wr] <= w_sel_eop;
        r_wr            <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_xfer} - {1'b0, w_pop};
    end
  end
`else
  // Combinational pass-through of the granted input
  always_comb begin
    w_dn_rdy          = out_ready;
    out_valid         = w_sel_valid;
    out_data          = (w_busy0 || w_busy1) ? w_sel_data : '0;
    out_channel       = (w_busy0 || w_busy1) ? w_sel_ch : '0;
    out_startofpacket = w_sel_valid && w_sel_sop;
    out_endofpacket   = w_sel_valid && w_sel_eop;
  end
`endif

endmodule

// File: tb/tb_ddr2_v11_0_if_csr_m0_chan_arbiter.sv
// Directed bench for the two-input packet arbiter.
// Queue-fed sources, negedge monitor, per-scenario inline checks.
`timescale 1ns/1ps
module tb_ddr2_v11_0_if_csr_m0_chan_arbiter;

`ifdef DDR2_V11_0_IF_CSR_M0_CHAN_ARBITER_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_startofpacket, in1_startofpacket;
  logic       in0_endofpacket, in1_endofpacket;
  logic       out_valid, out_ready;
  logic [7:0] out_data, out_channel;
  logic       out_startofpacket, out_endofpacket;
  logic [1:0] grant;
  logic       sop_err;

  ddr2_v11_0_if_csr_m0_chan_arbiter dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in1_valid(in1_valid),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .in0_data(in0_data), .in1_data(in1_data),
    .in0_startofpacket(in0_startofpacket),
    .in1_startofpacket(in1_startofpacket),
    .in0_endofpacket(in0_endofpacket),
    .in1_endofpacket(in1_endofpacket),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_channel(out_channel),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .grant(grant), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  typedef logic [9:0] beat_t;
  typedef struct {
    logic [17:0] v;
    int          c;
  } ob_t;

  beat_t q0[$];
  beat_t q1[$];
  logic  h0 = 1'b0;
  logic  h1 = 1'b0;
  logic  a0 = 1'b0;
  logic  a1 = 1'b0;
  int    cyc = 0;
  ob_t   mo[$];
  int    acc0[$];
  int    errc[$];
  int    nvec = 0;
  int    nbad = 0;

  function automatic beat_t bt(logic s, logic e, logic [7:0] d);
    return {s, e, d};
  endfunction

  function automatic logic [17:0] ex(logic [7:0] ch, logic [7:0] d,
                                     logic s, logic e);
    return {ch, d, s, e};
  endfunction

  function automatic void drive();
    in0_valid = (q0.size() != 0) && !h0;
    in1_valid = (q1.size() != 0) && !h1;
    {in0_startofpacket, in0_endofpacket, in0_data} =
      (q0.size() != 0) ? q0[0] : 10'd0;
    {in1_startofpacket, in1_endofpacket, in1_data} =
      (q1.size() != 0) ? q1[0] : 10'd0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (a0 && q0.size() != 0) q0.delete(0);
    if (a1 && q1.size() != 0) q1.delete(0);
    a0 = 1'b0;
    a1 = 1'b0;
    drive();
  end

  initial forever begin
    ob_t o;
    @(negedge clk);
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    if (a0) acc0.push_back(cyc);
    if (out_valid && out_ready) begin
      o.v = {out_channel, out_data, out_startofpacket, out_endofpacket};
      o.c = cyc;
      mo.push_back(o);
    end
    if (sop_err) errc.push_back(cyc);
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    q0 = {bt(1,0,8'h01), bt(0,1,8'h02), bt(1,0,8'h03), bt(0,1,8'h04)};
    q1 = {bt(1,0,8'h11), bt(0,1,8'h12), bt(1,0,8'h13), bt(0,1,8'h14)};
    drive();
    step(3);
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nbad++;
      $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    nvec++; if (in0_ready !== 1'b0) begin nbad++;
      $display("FAIL rst_in0_ready got %b exp 0", in0_ready); end
    nvec++; if (in1_ready !== 1'b0) begin nbad++;
      $display("FAIL rst_in1_ready got %b exp 0", in1_ready); end
    nvec++; if (grant !== 2'b00) begin nbad++;
      $display("FAIL rst_grant got %b exp 00", grant); end
    nvec++; if (out_channel !== 8'd0) begin nbad++;
      $display("FAIL rst_channel got %h exp 00", out_channel); end
    nvec++; if (out_data !== 8'd0) begin nbad++;
      $display("FAIL rst_data got %h exp 00", out_data); end
    nvec++; if ({out_startofpacket, out_endofpacket} !== 2'b00) begin
      nbad++;
      $display("FAIL rst_sop_eop got %b%b exp 00",
               out_startofpacket, out_endofpacket); end
    nvec++; if (sop_err !== 1'b0) begin nbad++;
      $display("FAIL rst_sop_err got %b exp 0", sop_err); end
    nvec++; if (mo.size() !== 0) begin nbad++;
      $display("FAIL rst_no_beats got %0d exp 0", mo.size()); end
  endtask

  task automatic test_tie();
    logic [17:0] e [8];
    e = '{ex(0,8'h01,1,0), ex(0,8'h02,0,1), ex(1,8'h11,1,0),
          ex(1,8'h12,0,1), ex(0,8'h03,1,0), ex(0,8'h04,0,1),
          ex(1,8'h13,1,0), ex(1,8'h14,0,1)};
    @(posedge clk);
    #2;
    mo.delete();
    reset = 1'b0;
    for (int i = 0; i < 60 && mo.size() < 8; i++) @(negedge clk);
    nvec++;
    if (mo.size() != 8) begin
      nbad++;
      $display("FAIL tie_count got %0d exp 8", mo.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin
          nbad++;
          $display("FAIL tie_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
      end
      nvec++;
      if (mo[1].c - mo[0].c !== 1) begin nbad++;
        $display("FAIL tie_b2b got %0d exp 1", mo[1].c - mo[0].c); end
      for (int i = 1; i < 7; i += 2) begin
        nvec++;
        if (mo[i+1].c - mo[i].c !== 2) begin
          nbad++;
          $display("FAIL tie_gap%0d got %0d exp 2", i,
                   mo[i+1].c - mo[i].c);
        end
      end
    end
  endtask

  task automatic test_single();
    logic        seen = 1'b0;
    logic        r1 = 1'b0;
    logic [17:0] e [3];
    e = '{ex(0,8'hA1,1,0), ex(0,8'hA2,0,0), ex(0,8'hA3,0,1)};
    step(2);
    mo.delete();
    acc0.delete();
    q0 = {bt(1,0,8'hA1), bt(0,0,8'hA2), bt(0,1,8'hA3)};
    drive();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (grant === 2'b01) seen = 1'b1;
      if (grant === 2'b01 && in1_ready !== 1'b0) r1 = 1'b1;
    end
    nvec++; if (seen !== 1'b1) begin nbad++;
      $display("FAIL single_grant got %b exp 1", seen); end
    nvec++; if (r1 !== 1'b0) begin nbad++;
      $display("FAIL single_in1_ready got %b exp 0", r1); end
    nvec++;
    if (mo.size() != 3 || acc0.size() != 3) begin
      nbad++;
      $display("FAIL single_count got %0d/%0d exp 3/3",
               mo.size(), acc0.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin nbad++;
          $display("FAIL single_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
        nvec++;
        if (mo[i].c - acc0[i] !== LAT) begin nbad++;
          $display("FAIL single_lat%0d got %0d exp %0d", i,
                   mo[i].c - acc0[i], LAT);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] e [5];
    e = '{ex(1,8'h10,1,0), ex(1,8'h11,0,0), ex(1,8'h12,0,0),
          ex(1,8'h13,0,1), ex(0,8'h55,1,1)};
    step(2);
    mo.delete();
    q1 = {bt(1,0,8'h10), bt(0,0,8'h11), bt(0,0,8'h12), bt(0,1,8'h13)};
    q0 = {bt(1,1,8'h55)};
    drive();
    for (int i = 0; i < 40 && mo.size() < 5; i++) begin
      step(1);
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    step(3);
    nvec++;
    if (mo.size() != 5) begin
      nbad++;
      $display("FAIL bp_count got %0d exp 5", mo.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin nbad++;
          $display("FAIL bp_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [17:0] e [4];
    e = '{ex(0,8'h21,1,0), ex(0,8'h22,0,0), ex(0,8'h23,0,1),
          ex(1,8'h31,1,1)};
    step(2);
    mo.delete();
    acc0.delete();
    q0 = {bt(1,0,8'h21), bt(0,0,8'h22), bt(0,1,8'h23)};
    drive();
    for (int i = 0; i < 20 && acc0.size() < 1; i++) @(negedge clk);
    step(1);
    h0 = 1'b1;
    q1 = {bt(1,1,8'h31)};
    drive();
    step(3);
    @(negedge clk);
    nvec++; if (grant !== 2'b01) begin nbad++;
      $display("FAIL stall_grant got %b exp 01", grant); end
    nvec++; if (in1_ready !== 1'b0) begin nbad++;
      $display("FAIL stall_in1_ready got %b exp 0", in1_ready); end
    nvec++; if (acc0.size() !== 1) begin nbad++;
      $display("FAIL stall_accepted got %0d exp 1", acc0.size()); end
    step(1);
    h0 = 1'b0;
    drive();
    for (int i = 0; i < 30 && mo.size() < 4; i++) @(negedge clk);
    nvec++;
    if (mo.size() != 4) begin
      nbad++;
      $display("FAIL stall_count got %0d exp 4", mo.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin nbad++;
          $display("FAIL stall_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
      end
    end
  endtask

  task automatic test_sop_err();
    logic [17:0] e [4];
    e = '{ex(0,8'h41,1,0), ex(0,8'h42,0,0), ex(0,8'h43,1,0),
          ex(0,8'h44,0,1)};
    step(2);
    mo.delete();
    acc0.delete();
    errc.delete();
    q0 = {bt(1,0,8'h41), bt(0,0,8'h42), bt(1,0,8'h43), bt(0,1,8'h44)};
    drive();
    for (int i = 0; i < 30 && mo.size() < 4; i++) @(negedge clk);
    step(3);
    nvec++;
    if (errc.size() !== 1) begin nbad++;
      $display("FAIL sop_err_pulses got %0d exp 1", errc.size()); end
    nvec++;
    if (errc.size() < 1 || acc0.size() < 3) begin
      nbad++;
      $display("FAIL sop_err_when got %0d/%0d records exp >=1/>=3",
               errc.size(), acc0.size());
    end else if (errc[0] !== acc0[2] + 1) begin
      nbad++;
      $display("FAIL sop_err_when got cyc %0d exp %0d",
               errc[0], acc0[2] + 1);
    end
    nvec++;
    if (mo.size() != 4) begin
      nbad++;
      $display("FAIL sop_err_count got %0d exp 4", mo.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin nbad++;
          $display("FAIL sop_err_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] e [2];
    e = '{ex(0,8'h71,1,1), ex(1,8'h81,1,1)};
    step(2);
    acc0.delete();
    q0 = {bt(1,0,8'h61), bt(0,0,8'h62), bt(0,0,8'h63), bt(0,1,8'h64)};
    drive();
    for (int i = 0; i < 20 && acc0.size() < 2; i++) @(negedge clk);
    step(1);
    reset = 1'b1;
    q0.delete();
    drive();
    step(1);
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nbad++;
      $display("FAIL mrst_out_valid got %b exp 0", out_valid); end
    nvec++; if (grant !== 2'b00) begin nbad++;
      $display("FAIL mrst_grant got %b exp 00", grant); end
    step(1);
    mo.delete();
    q0 = {bt(1,1,8'h71)};
    q1 = {bt(1,1,8'h81)};
    drive();
    reset = 1'b0;
    for (int i = 0; i < 30 && mo.size() < 2; i++) @(negedge clk);
    step(4);
    nvec++;
    if (mo.size() != 2) begin
      nbad++;
      $display("FAIL mrst_count got %0d exp 2", mo.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (mo[i].v !== e[i]) begin nbad++;
          $display("FAIL mrst_beat%0d got %h exp %h", i, mo[i].v, e[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    drive();
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_stall();
    test_sop_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
